// File: rtl/demorgan_equiv_sequencer.sv
// Exhaustive self-check sequencer: walks every N_INPUTS-bit vector, compares two forms, reports result.
// Optional build macro DEMORGAN_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatch.
module demorgan_equiv_sequencer #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_INPUTS-1:0] vec,
  input  logic                lhs_d,
  input  logic                rhs_d,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   mismatch_cnt,
  output logic [N_INPUTS-1:0] first_fail_vec
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int MW  = N_INPUTS + 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t              state, state_nxt;
  logic [SCW-1:0]      cnt, cnt_nxt;
  logic [N_INPUTS-1:0] vec_nxt, ff_nxt;
  logic [MW-1:0]       mm_nxt;
  logic                pass_nxt, done_nxt, miss;

  assign miss = lhs_d ^ rhs_d;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      vec            <= '0;
      mismatch_cnt   <= '0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      vec            <= vec_nxt;
      mismatch_cnt   <= mm_nxt;
      first_fail_vec <= ff_nxt;
      pass           <= pass_nxt;
      done           <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vec_nxt   = vec;
    mm_nxt    = mismatch_cnt;
    ff_nxt    = first_fail_vec;
    pass_nxt  = pass;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
          vec_nxt   = '0;
          mm_nxt    = '0;
          ff_nxt    = '0;
          pass_nxt  = 1'b0;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt + SCW'(1);
        if (cnt == SETTLE_LAST) state_nxt = CHECK;
      end
      CHECK: begin
        // count never exceeds 2**N_INPUTS, so MW bits cannot wrap
        if (miss) begin
          mm_nxt = mismatch_cnt + MW'(1);
          if (mismatch_cnt == '0) ff_nxt = vec;
        end
`ifdef DEMORGAN_SEQ_STOP_ON_FAIL_EN
        if (miss) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          pass_nxt  = 1'b0;
        end else
`endif
        if (vec != '1) begin
          vec_nxt   = vec + N_INPUTS'(1);
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end else begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          pass_nxt  = (mm_nxt == '0);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_demorgan_equiv_sequencer.sv
// Directed bench for demorgan_equiv_sequencer: table of fault modes plus re-pulse and mid-run reset sequences.
module tb_demorgan_equiv_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, lhs_d, rhs_d;
  logic [2:0] vec, first_fail_vec;
  logic [3:0] mismatch_cnt;
  logic       busy, done, pass;
  int         mode;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  demorgan_equiv_sequencer #(.N_INPUTS(3), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec), .lhs_d(lhs_d), .rhs_d(rhs_d),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_fail_vec(first_fail_vec)
  );

  // Forms under test; mode selects which vectors get a forced fault on rhs_d.
  always_comb begin
    logic a, b, c;
    a = vec[0]; b = vec[1]; c = vec[2];
    lhs_d = (~a | ~b) & ~c;
    rhs_d = ~(a & b) & ~c;
    case (mode)
      1: if (vec == 3'd5) rhs_d = ~rhs_d;
      2: rhs_d = ~lhs_d;
      3: if (vec == 3'd2 || vec == 3'd6) rhs_d = ~rhs_d;
      default: ;
    endcase
  end

  typedef struct {
    int   mode;
    bit   repulse;
    int   lat;
    int   cnt;
    int   first;
    int   vend;
    bit   pass;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t t);
    mode = t.mode;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < t.lat; k++) begin
      @(negedge clk);
      start = t.repulse && (k == 2 || k == 9);
      chk("busy_in_run", busy, 1);
      chk("no_early_done", done, 0);
      chk("vec_seq", vec, k / 2);
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    chk("vec_end", vec, t.vend);
    chk("mismatch_cnt", mismatch_cnt, t.cnt);
    chk("first_fail_vec", first_fail_vec, t.first);
    chk("pass", pass, t.pass);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_cnt", mismatch_cnt, t.cnt);
    chk("hold_pass", pass, t.pass);
  endtask

  initial begin
    tbl[0] = '{0, 1'b0, 16, 0, 0, 7, 1'b1};
`ifdef DEMORGAN_SEQ_STOP_ON_FAIL_EN
    tbl[1] = '{1, 1'b0, 12, 1, 5, 5, 1'b0};
    tbl[2] = '{2, 1'b0,  2, 1, 0, 0, 1'b0};
    tbl[3] = '{3, 1'b0,  6, 1, 2, 2, 1'b0};
`else
    tbl[1] = '{1, 1'b0, 16, 1, 5, 7, 1'b0};
    tbl[2] = '{2, 1'b0, 16, 8, 0, 7, 1'b0};
    tbl[3] = '{3, 1'b0, 16, 2, 2, 7, 1'b0};
`endif
    tbl[4] = '{0, 1'b1, 16, 0, 0, 7, 1'b1};

    mode = 0; start = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vec", vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cnt", mismatch_cnt, 0);
    chk("rst_first", first_fail_vec, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run(tbl[i]);

    // Abort a run while vec==4 (SETTLE after edge 8), with prior results nonzero.
    run(tbl[2]);
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_abort_vec", vec, 4);
    #2 rst = 1'b1;
    #1;
    chk("abort_vec", vec, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", mismatch_cnt, 0);
    chk("abort_first", first_fail_vec, 0);
    chk("abort_pass", pass, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("no_done_after_abort", done, 0);
      chk("idle_after_abort", busy, 0);
    end
    run(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
